mem_arbiter: RTL and testbench

Sequences a single shared memory port between the instruction-fetch requester and the data-memory requester of the processor, so fetch and load/store use one unified memory. It sits between the fetch/memory stages and the backing memory. It grants one requester at a time, registers the request, waits for the memory's completion, then returns read data with a one-cycle done pulse. Stall outputs freeze the requesting stage while its access is pending.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_timeout.sv | 32 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified-memory arbiter.
// No logic is defined here, so there is no latency.
// No handshaking is defined here, so there is no backpressure behaviour.
package mem_arb_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_TIMEOUT = 64;

    // The fourth encoding is unused. The arbiter treats it as an illegal state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Watchdog for one memory access. It flags an access that has run TIMEOUT cycles with no completion.
// Latency: 'expired' is combinational. It is high in the TIMEOUT-th consecutive enabled cycle.
// Backpressure: none. 'clr' restarts the count and 'en' advances it.
module mem_arb_timeout #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Count the cycles spent waiting. The count restarts at every new grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data load/store. Arbitration is round-robin on ties.
// Latency: the request is granted in T0, the memory is enabled from T1, and done arrives the cycle after mem_done.
// Backpressure: each stall output holds its requesting stage until done. Optional watchdog: MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    input  logic              halt,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              err
);

    state_t state, state_nxt;
    owner_t owner, last_owner, grant_own;
    logic   grant, rsp, bad_state, tmo_abort, expired;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (grant),
        .en      ((state == ST_BUSY) && !mem_done),
        .expired (expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign expired        = 1'b0;
`endif

    // Next state, grant selection and completion decode.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_own = OWN_I;
        rsp       = 1'b0;
        bad_state = 1'b0;
        tmo_abort = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!halt && (i_req || d_req)) begin
                    grant     = 1'b1;
                    state_nxt = ST_BUSY;
                    if (i_req && d_req) begin
                        grant_own = (last_owner == OWN_I) ? OWN_D : OWN_I;
                    end else if (d_req) begin
                        grant_own = OWN_D;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_done) begin
                    rsp       = 1'b1;
                    state_nxt = ST_RESP;
                end else if (expired) begin
                    tmo_abort = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: begin
                bad_state = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register. Reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture at grant, the done pulses, read-data return and the sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_I;
            last_owner <= OWN_I;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            err        <= 1'b0;
        end else begin
            mem_en <= (state_nxt == ST_BUSY);
            i_done <= rsp && (owner == OWN_I);
            d_done <= rsp && (owner == OWN_D);
            if (grant) begin
                owner      <= grant_own;
                last_owner <= grant_own;
                mem_addr   <= (grant_own == OWN_D) ? d_addr : i_addr;
                mem_wr     <= (grant_own == OWN_D) && d_wr;
                if (grant_own == OWN_D) begin
                    mem_wdata <= d_wdata;
                end
            end else if (state_nxt != ST_BUSY) begin
                mem_wr <= 1'b0;
            end
            if (rsp) begin
                if (owner == OWN_I) begin
                    i_rdata <= mem_rdata;
                end else if (!mem_wr) begin
                    d_rdata <= mem_rdata;
                end
            end
            if ((mem_done && (state != ST_BUSY)) || bad_state || tmo_abort) begin
                err <= 1'b1;
            end
        end
    end

    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter. Each row gives one cycle's inputs and expected outputs.
// Inputs are driven on the falling edge and outputs are sampled 1 ns later.
// The multi-cycle corner cases (reset mid-access, withdrawn request, watchdog) are written out by hand.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr, halt, mem_done;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_done, i_stall, d_done, d_stall, mem_en, mem_wr, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .halt(halt), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
    );

    // c = {i_req, d_req, d_wr, halt}; f = {mem_en, mem_wr, i_done, d_done, i_stall, d_stall, err}
    typedef struct {
        logic [3:0]  c;
        logic [15:0] ia, da, dwd, mrd;
        logic        md;
        logic [6:0]  f;
        logic [15:0] addr, wdata, ird, drd;
    } vec_t;

    vec_t vecs[30];

    function automatic logic [6:0] flags();
        return {mem_en, mem_wr, i_done, d_done, i_stall, d_stall, err};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [15:0] ia, da, dwd, mrd, input logic md);
        {i_req, d_req, d_wr, halt} = c;
        i_addr = ia; d_addr = da; d_wdata = dwd; mem_rdata = mrd; mem_done = md;
    endtask

    initial begin
        // ties from reset: D, then I, then D
        vecs[0]  = '{4'b1100, 16'h0AAA, 16'h0DDD, 16'h5555, 16'h0000, 1'b0, 7'b0000110, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{4'b1100, 16'h0AAA, 16'h0DDD, 16'h5555, 16'hD001, 1'b1, 7'b1000110, 16'h0DDD, 16'h5555, 16'h0000, 16'h0000};
        vecs[2]  = '{4'b1100, 16'h0AAA, 16'h0DDD, 16'h5555, 16'h0000, 1'b0, 7'b0001100, 16'h0DDD, 16'h5555, 16'h0000, 16'hD001};
        vecs[3]  = '{4'b1100, 16'h0AAA, 16'h0DDD, 16'h5555, 16'h0000, 1'b0, 7'b0000110, 16'h0DDD, 16'h5555, 16'h0000, 16'hD001};
        vecs[4]  = '{4'b1100, 16'h0AAA, 16'h0DDD, 16'h5555, 16'h1001, 1'b1, 7'b1000110, 16'h0AAA, 16'h5555, 16'h0000, 16'hD001};
        vecs[5]  = '{4'b1100, 16'h0AAA, 16'h0DDD, 16'h5555, 16'h0000, 1'b0, 7'b0010010, 16'h0AAA, 16'h5555, 16'h1001, 16'hD001};
        vecs[6]  = '{4'b1100, 16'h0AAA, 16'h0DDD, 16'h5555, 16'h0000, 1'b0, 7'b0000110, 16'h0AAA, 16'h5555, 16'h1001, 16'hD001};
        vecs[7]  = '{4'b1100, 16'h0AAA, 16'h0DDD, 16'h5555, 16'hD002, 1'b1, 7'b1000110, 16'h0DDD, 16'h5555, 16'h1001, 16'hD001};
        vecs[8]  = '{4'b0100, 16'h0AAA, 16'h0DDD, 16'h5555, 16'h0000, 1'b0, 7'b0001000, 16'h0DDD, 16'h5555, 16'h1001, 16'hD002};
        vecs[9]  = '{4'b0000, 16'h0AAA, 16'h0DDD, 16'h5555, 16'h0000, 1'b0, 7'b0000000, 16'h0DDD, 16'h5555, 16'h1001, 16'hD002};
        // single fetch, 1-cycle memory
        vecs[10] = '{4'b1000, 16'h0010, 16'h0DDD, 16'h5555, 16'h0000, 1'b0, 7'b0000100, 16'h0DDD, 16'h5555, 16'h1001, 16'hD002};
        vecs[11] = '{4'b1000, 16'h0010, 16'h0DDD, 16'h5555, 16'h1234, 1'b1, 7'b1000100, 16'h0010, 16'h5555, 16'h1001, 16'hD002};
        vecs[12] = '{4'b1000, 16'h0010, 16'h0DDD, 16'h5555, 16'h0000, 1'b0, 7'b0010000, 16'h0010, 16'h5555, 16'h1234, 16'hD002};
        vecs[13] = '{4'b0000, 16'h0010, 16'h0DDD, 16'h5555, 16'h0000, 1'b0, 7'b0000000, 16'h0010, 16'h5555, 16'h1234, 16'hD002};
        // data write, 3-cycle memory; operand changes while busy are ignored
        vecs[14] = '{4'b0110, 16'h0010, 16'h0100, 16'hBEEF, 16'h0000, 1'b0, 7'b0000010, 16'h0010, 16'h5555, 16'h1234, 16'hD002};
        vecs[15] = '{4'b0110, 16'h0010, 16'h0999, 16'h1111, 16'h0000, 1'b0, 7'b1100010, 16'h0100, 16'hBEEF, 16'h1234, 16'hD002};
        vecs[16] = '{4'b0110, 16'h0010, 16'h0999, 16'h1111, 16'h0000, 1'b0, 7'b1100010, 16'h0100, 16'hBEEF, 16'h1234, 16'hD002};
        vecs[17] = '{4'b0110, 16'h0010, 16'h0999, 16'h1111, 16'hFFFF, 1'b1, 7'b1100010, 16'h0100, 16'hBEEF, 16'h1234, 16'hD002};
        vecs[18] = '{4'b0110, 16'h0010, 16'h0999, 16'h1111, 16'h0000, 1'b0, 7'b0001000, 16'h0100, 16'hBEEF, 16'h1234, 16'hD002};
        vecs[19] = '{4'b0000, 16'h0010, 16'h0999, 16'h1111, 16'h0000, 1'b0, 7'b0000000, 16'h0100, 16'hBEEF, 16'h1234, 16'hD002};
        // halt blocks the grant; halt raised while busy lets the access finish
        vecs[20] = '{4'b1001, 16'h0020, 16'h0999, 16'h1111, 16'h0000, 1'b0, 7'b0000100, 16'h0100, 16'hBEEF, 16'h1234, 16'hD002};
        vecs[21] = '{4'b1001, 16'h0020, 16'h0999, 16'h1111, 16'h0000, 1'b0, 7'b0000100, 16'h0100, 16'hBEEF, 16'h1234, 16'hD002};
        vecs[22] = '{4'b1000, 16'h0020, 16'h0999, 16'h1111, 16'h0000, 1'b0, 7'b0000100, 16'h0100, 16'hBEEF, 16'h1234, 16'hD002};
        vecs[23] = '{4'b1001, 16'h0020, 16'h0999, 16'h1111, 16'h0000, 1'b0, 7'b1000100, 16'h0020, 16'hBEEF, 16'h1234, 16'hD002};
        vecs[24] = '{4'b1001, 16'h0020, 16'h0999, 16'h1111, 16'h2222, 1'b1, 7'b1000100, 16'h0020, 16'hBEEF, 16'h1234, 16'hD002};
        vecs[25] = '{4'b1001, 16'h0020, 16'h0999, 16'h1111, 16'h0000, 1'b0, 7'b0010000, 16'h0020, 16'hBEEF, 16'h2222, 16'hD002};
        vecs[26] = '{4'b0001, 16'h0020, 16'h0999, 16'h1111, 16'h0000, 1'b0, 7'b0000000, 16'h0020, 16'hBEEF, 16'h2222, 16'hD002};
        // stray mem_done in IDLE sets a sticky error
        vecs[27] = '{4'b0000, 16'h0020, 16'h0999, 16'h1111, 16'h0000, 1'b1, 7'b0000000, 16'h0020, 16'hBEEF, 16'h2222, 16'hD002};
        vecs[28] = '{4'b0000, 16'h0020, 16'h0999, 16'h1111, 16'h0000, 1'b0, 7'b0000001, 16'h0020, 16'hBEEF, 16'h2222, 16'hD002};
        vecs[29] = '{4'b0000, 16'h0020, 16'h0999, 16'h1111, 16'h0000, 1'b0, 7'b0000001, 16'h0020, 16'hBEEF, 16'h2222, 16'hD002};

        rst = 1'b1;
        drive(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset flags", {9'd0, flags()}, 16'h0000);
        chk("reset mem_addr", mem_addr, 16'h0000);
        chk("reset mem_wdata", mem_wdata, 16'h0000);
        chk("reset i_rdata", i_rdata, 16'h0000);
        chk("reset d_rdata", d_rdata, 16'h0000);
        rst = 1'b0;

        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            drive(vecs[k].c, vecs[k].ia, vecs[k].da, vecs[k].dwd, vecs[k].mrd, vecs[k].md);
            #1;
            chk($sformatf("row%0d flags", k), {9'd0, flags()}, {9'd0, vecs[k].f});
            chk($sformatf("row%0d mem_addr", k), mem_addr, vecs[k].addr);
            chk($sformatf("row%0d mem_wdata", k), mem_wdata, vecs[k].wdata);
            chk($sformatf("row%0d i_rdata", k), i_rdata, vecs[k].ird);
            chk($sformatf("row%0d d_rdata", k), d_rdata, vecs[k].drd);
        end

        // Reset during BUSY: mem_en drops without waiting for an edge, and no done follows.
        @(negedge clk);
        drive(4'b1000, 16'h0030, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        #1;
        chk("busy before reset mem_en", {15'd0, mem_en}, 16'h0001);
        rst = 1'b1;
        #1;
        chk("async reset mem_en", {15'd0, mem_en}, 16'h0000);
        chk("reset clears err", {15'd0, err}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        i_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post-reset idle%0d flags", k), {9'd0, flags()}, 16'h0000);
        end

        // A data read withdrawn while BUSY still completes and pulses done.
        @(negedge clk);
        drive(4'b0100, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        drive(4'b0000, 16'h0000, 16'h0040, 16'h0000, 16'h4444, 1'b1);
        #1;
        chk("withdrawn busy mem_addr", mem_addr, 16'h0040);
        @(negedge clk);
        drive(4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        #1;
        chk("withdrawn flags", {9'd0, flags()}, 16'h0008);
        chk("withdrawn d_rdata", d_rdata, 16'h4444);

`ifdef MEM_ARB_TIMEOUT_EN
        // Four BUSY cycles with no mem_done abort the access with err set and no i_done.
        @(negedge clk);
        drive(4'b1000, 16'h0050, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        i_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("timeout busy%0d flags", k), {9'd0, flags()}, 16'h0040);
            @(negedge clk);
        end
        #1;
        chk("timeout abort flags", {9'd0, flags()}, 16'h0001);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("timeout after%0d flags", k), {9'd0, flags()}, 16'h0001);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
